spectro_frame_receiver: RTL and testbench

Downstream consumer of the spectrogram extractor's serial readout interface, running on the serial readout clock. It deframes the two-lane bit stream into a 32-bit event timestamp followed by a sequence of paired 3-bit channel codes (ch1, ch2). Each decoded item is presented as a single-cycle valid pulse for a host-side FIFO/SPI bridge. Malformed frames (truncated timestamp, partial sample, sample overflow) are flagged.

---
 rtl/spectro_frame_receiver_pkg.sv | 36 +++
 rtl/spectro_frame_receiver_if.sv | 32 +++
 rtl/spectro_frame_receiver_rx_shift_lane.sv | 27 ++
 rtl/spectro_frame_receiver.sv | 200 ++++++++++++++++++++
 tb/tb_spectro_frame_receiver.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/spectro_frame_receiver_pkg.sv
// Shared constants and types for the spectrogram serial frame receiver.
package spectro_rx_pkg;

  localparam int TIME_BITS    = 32;
  localparam int CODE_BITS    = 3;
  localparam int MAX_SAMPLES  = 512;
  localparam int IDX_BITS     = $clog2(MAX_SAMPLES);
  localparam int CNT_BITS     = IDX_BITS + 1;
  localparam int BIT_CNT_BITS = $clog2(TIME_BITS);

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_TIME   = 2'd1;
  localparam state_t ST_SAMPLE = 2'd2;
  localparam state_t ST_DRAIN  = 2'd3;

  typedef enum logic [1:0] {
    ERR_NONE    = 2'b00,
    ERR_TIME    = 2'b01,
    ERR_PARTIAL = 2'b10,
    ERR_OVF     = 2'b11
  } err_code_t;

  // event_time field layout as packed by the extractor
  localparam int DAY_MSB  = 31;
  localparam int DAY_LSB  = 27;
  localparam int HOUR_MSB = 26;
  localparam int HOUR_LSB = 22;
  localparam int MIN_MSB  = 21;
  localparam int MIN_LSB  = 16;
  localparam int SEC_MSB  = 15;
  localparam int SEC_LSB  = 10;
  localparam int MS_MSB   = 9;
  localparam int MS_LSB   = 0;

endpackage

// File: rtl/spectro_frame_receiver_if.sv
// Serial readout stream plus decoded host-side outputs of the frame receiver.
interface spectro_frame_receiver_if;
  import spectro_rx_pkg::*;

  logic [1:0]             serial_in;
  logic                   serial_readout;
  logic                   sending_data;
  logic                   time_valid;
  logic [TIME_BITS-1:0]   event_time;
  logic                   sample_valid;
  logic [CODE_BITS-1:0]   ch1_code;
  logic [CODE_BITS-1:0]   ch2_code;
  logic [IDX_BITS-1:0]    sample_idx;
  logic                   frame_done;
  logic [CNT_BITS-1:0]    sample_count;
  logic                   frame_error;
  logic [1:0]             error_code;

  // master is the readout source / host side, slave is the receiver
  modport master (
    output serial_in, serial_readout, sending_data,
    input  time_valid, event_time, sample_valid, ch1_code, ch2_code,
           sample_idx, frame_done, sample_count, frame_error, error_code
  );

  modport slave (
    input  serial_in, serial_readout, sending_data,
    output time_valid, event_time, sample_valid, ch1_code, ch2_code,
           sample_idx, frame_done, sample_count, frame_error, error_code
  );

endinterface

// File: rtl/spectro_frame_receiver_rx_shift_lane.sv
// MSB-first shift register; next_value shows the word including the bit being strobed in.
module rx_shift_lane #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             shift,
  input  logic             bit_in,
  output logic [WIDTH-1:0] next_value
);

  logic [WIDTH-1:0] value;

  assign next_value = {value[WIDTH-2:0], bit_in};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      value <= '0;
    end else if (shift) begin
      value <= next_value;
    end else if (clear) begin
      value <= '0;
    end
  end

endmodule

// File: rtl/spectro_frame_receiver.sv
// Deframes the two-lane serial readout into a timestamp and paired channel codes,
// flagging truncated, partial and overflowing frames.
module spectro_frame_receiver
  import spectro_rx_pkg::*;
(
  input logic                  clk,
  input logic                  reset,
  spectro_frame_receiver_if.slave bus
);

  state_t                  state;
  logic                    sending_prev;
  logic [BIT_CNT_BITS-1:0] bit_cnt;
  logic [CNT_BITS-1:0]     sample_cnt;
  logic                    done_pend;

  logic                    time_valid;
  logic [TIME_BITS-1:0]    event_time;
  logic                    sample_valid;
  logic [CODE_BITS-1:0]    ch1_code;
  logic [CODE_BITS-1:0]    ch2_code;
  logic [IDX_BITS-1:0]     sample_idx;
  logic                    frame_done;
  logic [CNT_BITS-1:0]     sample_count;
  logic                    frame_error;
  err_code_t               error_code;

  logic                    rise;
  logic                    fall;
  logic                    time_shift;
  logic                    code_shift;
  logic                    time_last;
  logic                    code_last;
  logic                    lanes_clear;
  logic [TIME_BITS-1:0]    time_next;
  logic [CODE_BITS-1:0]    c1_next;
  logic [CODE_BITS-1:0]    c2_next;

  // The strobe on the envelope's rising edge already carries time bit 31.
  always_comb begin
    rise        = bus.sending_data && !sending_prev;
    fall        = !bus.sending_data && sending_prev;
    time_shift  = bus.serial_readout && ((state == ST_TIME) || ((state == ST_IDLE) && rise));
    code_shift  = bus.serial_readout && (state == ST_SAMPLE);
    time_last   = time_shift && (bit_cnt == BIT_CNT_BITS'(TIME_BITS - 1));
    code_last   = code_shift && (bit_cnt == BIT_CNT_BITS'(CODE_BITS - 1));
    lanes_clear = (state == ST_IDLE);
  end

  rx_shift_lane #(.WIDTH(TIME_BITS)) u_time_lane (
    .clk        (clk),
    .reset      (reset),
    .clear      (lanes_clear),
    .shift      (time_shift),
    .bit_in     (bus.serial_in[0]),
    .next_value (time_next)
  );

  rx_shift_lane #(.WIDTH(CODE_BITS)) u_c1_lane (
    .clk        (clk),
    .reset      (reset),
    .clear      (lanes_clear),
    .shift      (code_shift),
    .bit_in     (bus.serial_in[0]),
    .next_value (c1_next)
  );

  rx_shift_lane #(.WIDTH(CODE_BITS)) u_c2_lane (
    .clk        (clk),
    .reset      (reset),
    .clear      (lanes_clear),
    .shift      (code_shift),
    .bit_in     (bus.serial_in[1]),
    .next_value (c2_next)
  );

  // A frame ending on the same strobe that completed an item defers frame_done
  // by one cycle through done_pend, keeping the pulses apart.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sending_prev <= 1'b0;
      bit_cnt      <= '0;
      sample_cnt   <= '0;
      done_pend    <= 1'b0;
      time_valid   <= 1'b0;
      event_time   <= '0;
      sample_valid <= 1'b0;
      ch1_code     <= '0;
      ch2_code     <= '0;
      sample_idx   <= '0;
      frame_done   <= 1'b0;
      sample_count <= '0;
      frame_error  <= 1'b0;
      error_code   <= ERR_NONE;
    end else begin
      sending_prev <= bus.sending_data;
      time_valid   <= 1'b0;
      sample_valid <= 1'b0;
      frame_done   <= 1'b0;
      frame_error  <= 1'b0;

      if (done_pend) begin
        frame_done <= 1'b1;
        done_pend  <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          bit_cnt <= '0;
          if (rise) begin
            state   <= ST_TIME;
            bit_cnt <= time_shift ? BIT_CNT_BITS'(1) : '0;
          end
        end

        ST_TIME: begin
          if (time_last) begin
            event_time <= time_next;
            time_valid <= 1'b1;
            bit_cnt    <= '0;
            sample_cnt <= '0;
            if (fall) begin
              sample_count <= '0;
              done_pend    <= 1'b1;
              state        <= ST_IDLE;
            end else begin
              state <= ST_SAMPLE;
            end
          end else if (fall) begin
            frame_error <= 1'b1;
            error_code  <= ERR_TIME;
            bit_cnt     <= '0;
            state       <= ST_IDLE;
          end else if (time_shift) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_SAMPLE: begin
          if (code_last) begin
            bit_cnt <= '0;
            if (sample_cnt == CNT_BITS'(MAX_SAMPLES)) begin
              frame_error <= 1'b1;
              error_code  <= ERR_OVF;
              state       <= fall ? ST_IDLE : ST_DRAIN;
            end else begin
              ch1_code     <= c1_next;
              ch2_code     <= c2_next;
              sample_idx   <= sample_cnt[IDX_BITS-1:0];
              sample_valid <= 1'b1;
              sample_cnt   <= sample_cnt + 1'b1;
              if (fall) begin
                sample_count <= sample_cnt + 1'b1;
                done_pend    <= 1'b1;
                state        <= ST_IDLE;
              end
            end
          end else if (fall) begin
            bit_cnt <= '0;
            state   <= ST_IDLE;
            if (!code_shift && (bit_cnt == '0)) begin
              frame_done   <= 1'b1;
              sample_count <= sample_cnt;
            end else begin
              frame_error <= 1'b1;
              error_code  <= ERR_PARTIAL;
            end
          end else if (code_shift) begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end

        ST_DRAIN: begin
          bit_cnt <= '0;
          if (fall) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          state   <= ST_IDLE;
          bit_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.time_valid   = time_valid;
  assign bus.event_time   = event_time;
  assign bus.sample_valid = sample_valid;
  assign bus.ch1_code     = ch1_code;
  assign bus.ch2_code     = ch2_code;
  assign bus.sample_idx   = sample_idx;
  assign bus.frame_done   = frame_done;
  assign bus.sample_count = sample_count;
  assign bus.frame_error  = frame_error;
  assign bus.error_code   = error_code;

endmodule

// File: tb/tb_spectro_frame_receiver.sv
// Directed and randomized frames; decoded pulses are collected and compared
// against outcomes derived from the framing rules.
module tb_spectro_frame_receiver;
  import spectro_rx_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;

  spectro_frame_receiver_if bus();

  spectro_frame_receiver dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] got_time[$];
  logic [31:0] got_samp[$];
  int          got_done[$];
  int          got_err[$];

  logic [2:0] c1_tab [0:599];
  logic [2:0] c2_tab [0:599];
  int last_err = 0;
  int last_count = 0;

  // Pulse collector, sampled on the falling edge
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.time_valid)   got_time.push_back(bus.event_time);
      if (bus.sample_valid) got_samp.push_back(32'({bus.sample_idx, bus.ch1_code, bus.ch2_code}));
      if (bus.frame_done)   got_done.push_back(int'(bus.sample_count));
      if (bus.frame_error)  got_err.push_back(int'(bus.error_code));
    end
  end

  task automatic compareValue(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkAllZero(input string tag);
    compareValue({tag, ".time_valid"},   32'(bus.time_valid), 32'd0);
    compareValue({tag, ".event_time"},   bus.event_time, 32'd0);
    compareValue({tag, ".sample_valid"}, 32'(bus.sample_valid), 32'd0);
    compareValue({tag, ".ch1_code"},     32'(bus.ch1_code), 32'd0);
    compareValue({tag, ".ch2_code"},     32'(bus.ch2_code), 32'd0);
    compareValue({tag, ".sample_idx"},   32'(bus.sample_idx), 32'd0);
    compareValue({tag, ".frame_done"},   32'(bus.frame_done), 32'd0);
    compareValue({tag, ".sample_count"}, 32'(bus.sample_count), 32'd0);
    compareValue({tag, ".frame_error"},  32'(bus.frame_error), 32'd0);
    compareValue({tag, ".error_code"},   32'(bus.error_code), 32'd0);
  endtask

  task automatic driveBit(input logic b0, input logic b1, input int gap);
    bus.serial_in = {b1, b0};
    bus.serial_readout = 1'b1;
    @(posedge clk); #1;
    bus.serial_readout = 1'b0;
    repeat (gap) begin
      bus.serial_in = 2'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic midReset();
    reset = 1'b1;
    #1;
    checkAllZero("reset_mid");
    bus.sending_data = 1'b0;
    bus.serial_readout = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    last_err = 0;
    last_count = 0;
  endtask

  // One frame: time_bits of the timestamp, n whole samples, then extra bits of a
  // further sample. rst_at > 0 aborts with reset after that many strobes.
  task automatic applyStimulus(input logic [31:0] t, input int time_bits, input int n,
                               input int extra, input int gap, input int rst_at);
    int sent;
    sent = 0;
    got_time.delete(); got_samp.delete(); got_done.delete(); got_err.delete();
    @(posedge clk); #1;
    bus.sending_data = 1'b1;
    for (int k = 0; k < time_bits; k++) begin
      driveBit(t[31-k], 1'($urandom), gap);
      sent++;
      if (sent == rst_at) begin midReset(); return; end
    end
    for (int s = 0; s < n; s++) begin
      for (int j = 2; j >= 0; j--) begin
        driveBit(c1_tab[s][j], c2_tab[s][j], gap);
        sent++;
        if (sent == rst_at) begin midReset(); return; end
      end
    end
    for (int j = 0; j < extra; j++) driveBit(1'($urandom), 1'($urandom), gap);
    bus.sending_data = 1'b0;
    @(posedge clk); #1;
    repeat (6) begin
      bus.serial_readout = 1'($urandom);
      bus.serial_in = 2'($urandom);
      @(posedge clk); #1;
    end
    bus.serial_readout = 1'b0;
  endtask

  // Expected outcome of a frame from the framing rules alone
  task automatic checkOutput(input string tag, input logic [31:0] t, input int time_bits,
                             input int n, input int extra);
    int exp_time_cnt, exp_emit, exp_done, exp_err, lim;
    if (time_bits < TIME_BITS) begin
      exp_time_cnt = 0; exp_emit = 0; exp_done = -1; exp_err = 1;
    end else begin
      exp_time_cnt = 1;
      if (n > MAX_SAMPLES) begin
        exp_emit = MAX_SAMPLES; exp_done = -1; exp_err = 3;
      end else if (extra > 0) begin
        exp_emit = n; exp_done = -1; exp_err = 2;
      end else begin
        exp_emit = n; exp_done = n; exp_err = -1;
      end
    end
    compareValue({tag, ".time_pulses"}, 32'(got_time.size()), 32'(exp_time_cnt));
    if (exp_time_cnt == 1 && got_time.size() > 0)
      compareValue({tag, ".event_time"}, got_time[0], t);
    compareValue({tag, ".sample_pulses"}, 32'(got_samp.size()), 32'(exp_emit));
    lim = (got_samp.size() < exp_emit) ? got_samp.size() : exp_emit;
    for (int i = 0; i < lim; i++)
      compareValue($sformatf("%s.sample%0d", tag, i), got_samp[i],
                   32'({9'(i), c1_tab[i], c2_tab[i]}));
    compareValue({tag, ".done_pulses"}, 32'(got_done.size()), (exp_done >= 0) ? 32'd1 : 32'd0);
    if (exp_done >= 0 && got_done.size() > 0)
      compareValue({tag, ".sample_count"}, 32'(got_done[0]), 32'(exp_done));
    compareValue({tag, ".error_pulses"}, 32'(got_err.size()), (exp_err >= 0) ? 32'd1 : 32'd0);
    if (exp_err >= 0 && got_err.size() > 0)
      compareValue({tag, ".error_code"}, 32'(got_err[0]), 32'(exp_err));
    if (exp_err >= 0) last_err = exp_err;
    if (exp_done >= 0) last_count = exp_done;
    compareValue({tag, ".error_code_hold"}, 32'(bus.error_code), 32'(last_err));
    compareValue({tag, ".sample_count_hold"}, 32'(bus.sample_count), 32'(last_count));
  endtask

  task automatic fillPlanCodes();
    c1_tab[0] = 3'd3; c2_tab[0] = 3'd5;
    c1_tab[1] = 3'd7; c2_tab[1] = 3'd0;
    c1_tab[2] = 3'd1; c2_tab[2] = 3'd6;
  endtask

  task automatic fillRandomCodes();
    for (int i = 0; i < 600; i++) begin
      c1_tab[i] = 3'($urandom);
      c2_tab[i] = 3'($urandom);
    end
  endtask

  initial begin
    logic [31:0] t;
    int kind, n, tb, extra, gap;

    bus.serial_in = 2'b00;
    bus.serial_readout = 1'b0;
    bus.sending_data = 1'b0;

    #2 reset = 1'b1;
    #3;
    checkAllZero("reset_init");
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    $display("[TB] directed frame, strobe every cycle");
    fillPlanCodes();
    applyStimulus(32'hA5C3_0F12, 32, 3, 0, 0, 0);
    checkOutput("plan_fast", 32'hA5C3_0F12, 32, 3, 0);

    $display("[TB] directed frame, strobe every 4th cycle");
    applyStimulus(32'hA5C3_0F12, 32, 3, 0, 3, 0);
    checkOutput("plan_gap", 32'hA5C3_0F12, 32, 3, 0);

    $display("[TB] truncated timestamp");
    applyStimulus(32'h1234_5678, 20, 0, 0, 1, 0);
    checkOutput("trunc_time", 32'h1234_5678, 20, 0, 0);

    $display("[TB] partial sample");
    fillRandomCodes();
    applyStimulus(32'h0BAD_F00D, 32, 1, 2, 0, 0);
    checkOutput("partial", 32'h0BAD_F00D, 32, 1, 2);
    applyStimulus(32'h7654_3210, 32, 4, 0, 1, 0);
    checkOutput("after_partial", 32'h7654_3210, 32, 4, 0);

    $display("[TB] zero-sample frame");
    applyStimulus(32'hFFFF_0001, 32, 0, 0, 2, 0);
    checkOutput("empty", 32'hFFFF_0001, 32, 0, 0);

    $display("[TB] sample overflow");
    applyStimulus(32'hCAFE_BABE, 32, MAX_SAMPLES + 1, 0, 0, 0);
    checkOutput("overflow", 32'hCAFE_BABE, 32, MAX_SAMPLES + 1, 0);
    fillRandomCodes();
    applyStimulus(32'h0102_0304, 32, 5, 0, 0, 0);
    checkOutput("after_ovf", 32'h0102_0304, 32, 5, 0);

    $display("[TB] reset mid-sample");
    applyStimulus(32'hDEAD_BEEF, 32, 5, 0, 0, 32 + 3 * 2 + 1);
    compareValue("reset_frame.time_pulses", 32'(got_time.size()), 32'd1);
    compareValue("reset_frame.sample_pulses", 32'(got_samp.size()), 32'd2);
    compareValue("reset_frame.done_pulses", 32'(got_done.size()), 32'd0);
    compareValue("reset_frame.error_pulses", 32'(got_err.size()), 32'd0);
    applyStimulus(32'h5A5A_A5A5, 32, 3, 0, 1, 0);
    checkOutput("after_reset", 32'h5A5A_A5A5, 32, 3, 0);

    $display("[TB] randomized frames");
    for (int i = 0; i < 8; i++) begin
      fillRandomCodes();
      t = $urandom;
      kind = $urandom_range(0, 2);
      gap = $urandom_range(0, 3);
      tb = (kind == 1) ? $urandom_range(1, 31) : 32;
      n = (kind == 1) ? 0 : $urandom_range(0, 6);
      extra = (kind == 2) ? $urandom_range(1, 2) : 0;
      applyStimulus(t, tb, n, extra, gap, 0);
      checkOutput($sformatf("rand%0d", i), t, tb, n, extra);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
